// File: rtl/cg_pkg.sv
// Shared types and defaults for the clock-gate controller.
//   cg_state_e      : controller state encoding (2 bits)
//   *_DEF constants : default parameter values for clk_gate_ctrl
`timescale 1ns/1ps
package cg_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } cg_state_e;

  localparam int unsigned IDLE_CYCLES_DEF = 16;
  localparam int unsigned WAKE_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 8;

endpackage

// File: rtl/icg_cell.sv
// Behavioural integrated clock gate: low-transparent latch plus AND gate.
// Replaced by the library ICG cell at synthesis.
//   clk     : free-running clock
//   en      : functional enable (1 = clock runs)
//   test_en : scan override enable
//   gclk    : gated clock output
`timescale 1ns/1ps
module icg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_l;

  // Enable may only change while clk is low, so gclk never sees a partial pulse.
  always_latch begin
    if (!clk) en_l <= en | test_en;
  end

  assign gclk = en_l & clk;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: counts idle cycles with hysteresis, gates the domain
// clock after a one-cycle drain, and restores it with a settle window on wake.
//   clk         : free-running clock
//   rst         : asynchronous reset, active-low
//   busy_i      : domain has work in flight (ignored while gated)
//   wake_req_i  : request for the domain clock (level or pulse)
//   force_on_i  : override, clock never gated while high
//   scan_en_i   : scan mode, ICG enable forced on
//   gate_en_o   : registered ICG enable (1 = clock runs)
//   clk_gated_o : gated clock to the domain
//   ready_o     : clock running and settled
//   sleep_o     : domain clock currently gated
`timescale 1ns/1ps
module clk_gate_ctrl
  import cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic wake_req_i,
  input  logic force_on_i,
  input  logic scan_en_i,
  output logic gate_en_o,
  output logic clk_gated_o,
  output logic ready_o,
  output logic sleep_o
);

  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  // Reject illegal configurations at elaboration.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $fatal(1, "clk_gate_ctrl: CNT_W out of range");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > CNT_MAX) begin : g_bad_idle
    $fatal(1, "clk_gate_ctrl: IDLE_CYCLES out of range");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > CNT_MAX) begin : g_bad_wake
    $fatal(1, "clk_gate_ctrl: WAKE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             ready_q, ready_d;
  logic             sleep_q, sleep_d;
  logic             idle;

  // Saturating increment; the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  assign idle = !busy_i && !wake_req_i && !force_on_i;

  // State, counter and output registers; reset leaves the clock running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAKE;
      cnt_q     <= '0;
      gate_en_q <= 1'b1;
      ready_q   <= 1'b0;
      sleep_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
      ready_q   <= ready_d;
      sleep_q   <= sleep_d;
    end
  end

  // Next state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      RUN: begin
        if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      DRAIN: begin
        // Any activity (including a wake request) in the drain cycle aborts gating.
        cnt_d   = '0;
        state_d = idle ? GATED : RUN;
      end
      GATED: begin
        // busy_i comes from the stopped domain, so only wake/force can leave.
        cnt_d = '0;
        if (wake_req_i || force_on_i) state_d = WAKE;
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = WAKE;
        cnt_d   = '0;
      end
    endcase

    gate_en_d = (state_d != GATED);
    ready_d   = (state_d == RUN);
    sleep_d   = (state_d == GATED);
  end

  assign gate_en_o = gate_en_q;
  assign ready_o   = ready_q;
  assign sleep_o   = sleep_q;

  icg_cell u_icg (
    .clk     (clk),
    .en      (gate_en_q),
    .test_en (scan_en_i),
    .gclk    (clk_gated_o)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
`timescale 1ns/1ps
module tb_clk_gate_ctrl;

  logic clk;
  logic rst;
  logic busy, wake_req, force_on, scan_en;
  logic gate_en, clk_gated, ready, sleep;

  clk_gate_ctrl #(
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy_i      (busy),
    .wake_req_i  (wake_req),
    .force_on_i  (force_on),
    .scan_en_i   (scan_en),
    .gate_en_o   (gate_en),
    .clk_gated_o (clk_gated),
    .ready_o     (ready),
    .sleep_o     (sleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {gate_en, ready, sleep, clk_gated}
  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_g = 1'b1;

  task automatic check_pop();
    exp_t       e;
    logic [3:0] obs;
    obs = {gate_en, ready, sleep, clk_gated};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %b required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed gate/ready/sleep/gclk=%b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] exp);
    sb.push_back('{tag, exp});
    check_pop();
  endtask

  // One clock: push expectation, sample #1 after the edge while clk is high.
  // The gated clock in that high phase follows the enable the latch saw in the
  // preceding low phase: last registered gate_en or scan_en.
  task automatic step(input string tag, input logic g, input logic r, input logic s);
    sb.push_back('{tag, {g, r, s, last_g | scan_en}});
    @(posedge clk);
    #1;
    check_pop();
    last_g = g;
  endtask

  // Every gated-clock pulse must be a full half period.
  longint t_rise = 0;
  bit     rise_seen = 1'b0;
  always @(posedge clk_gated) begin
    t_rise    = $time;
    rise_seen = 1'b1;
  end
  always @(negedge clk_gated) begin
    if (rise_seen) begin
      n_cmp++;
      assert (($time - t_rise) === 64'd5) else begin
        n_err++;
        $error("FAIL gclk_pulse_width: observed %0d ns expected 5 ns", $time - t_rise);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; busy = 1'b0; wake_req = 1'b0; force_on = 1'b0; scan_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 4'b1001);
    last_g = 1'b1;

    // 1: release reset, idle domain gates after 4 idle + 1 drain
    rst = 1'b1;
    step("t1_wake", 1, 0, 0);
    step("t1_ready", 1, 1, 0);
    for (int i = 0; i < 3; i++) step("t1_idle", 1, 1, 0);
    step("t1_drain", 1, 0, 0);
    step("t1_gated", 0, 0, 1);
    step("t1_gated_hold", 0, 0, 1);

    // 6: scan forces the clock on while gated; busy ignored in GATED
    scan_en = 1'b1; busy = 1'b1;
    step("t6_scan_a", 0, 0, 1);
    step("t6_scan_b", 0, 0, 1);
    scan_en = 1'b0; busy = 1'b0;
    step("t6_scan_off", 0, 0, 1);

    // 3: single-cycle wake pulse
    wake_req = 1'b1;
    step("t3_wake", 1, 0, 0);
    wake_req = 1'b0;
    step("t3_settle", 1, 0, 0);
    step("t3_ready", 1, 1, 0);

    // 2: busy on idle cycle 3 restarts the idle count
    step("t2_idle1", 1, 1, 0);
    step("t2_idle2", 1, 1, 0);
    busy = 1'b1;
    step("t2_busy", 1, 1, 0);
    busy = 1'b0;
    for (int i = 0; i < 3; i++) step("t2_idle", 1, 1, 0);
    step("t2_drain", 1, 0, 0);
    step("t2_gated", 0, 0, 1);

    // 4: wake request in the drain cycle returns to RUN
    wake_req = 1'b1;
    step("t4_wake", 1, 0, 0);
    wake_req = 1'b0;
    step("t4_settle", 1, 0, 0);
    step("t4_ready", 1, 1, 0);
    for (int i = 0; i < 3; i++) step("t4_idle", 1, 1, 0);
    step("t4_drain", 1, 0, 0);
    wake_req = 1'b1;
    step("t4_abort", 1, 1, 0);
    wake_req = 1'b0;

    // 5: force_on holds the clock for 50 idle cycles
    force_on = 1'b1;
    for (int i = 0; i < 50; i++) step("t5_force", 1, 1, 0);
    force_on = 1'b0;
    for (int i = 0; i < 3; i++) step("t5_idle", 1, 1, 0);
    step("t5_drain", 1, 0, 0);
    step("t5_gated", 0, 0, 1);
    step("t5_gated_hold", 0, 0, 1);

    // 7: reset while gated turns the enable on asynchronously, no gclk glitch
    rst = 1'b0;
    #1;
    check_now("t7_async", 4'b1000);
    last_g = 1'b1;
    step("t7_hold", 1, 0, 0);
    rst = 1'b1;
    step("t7_wake", 1, 0, 0);
    step("t7_ready", 1, 1, 0);

    // force_on also wakes a gated domain
    for (int i = 0; i < 3; i++) step("t8_idle", 1, 1, 0);
    step("t8_drain", 1, 0, 0);
    step("t8_gated", 0, 0, 1);
    force_on = 1'b1;
    step("t8_wake", 1, 0, 0);
    step("t8_settle", 1, 0, 0);
    step("t8_ready", 1, 1, 0);
    step("t8_run", 1, 1, 0);
    force_on = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
